spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
Parametrised SPI master and successor to the fixed-frame SPI block. It adds run-time SPI mode (CPOL/CPHA), a variable frame length up to MAX_SIZE, a start/ready/done handshake and configurable chip-select setup/hold gaps. It sits between the motion controller and multiple SPI stepper-driver chips, sharing one bus across CS_SIZE chip selects. It runs entirely on the single system clock and has no internally derived clock domains.

Parameters:
MAX_SIZE, 40, maximum frame length in bits
CS_SIZE, 4, number of active-low chip-select lines
CLK_SIZE, 8, width of the clock divider count
CS_GAP, 1, SCLK half-periods between CS assert and the first SCLK edge, and between the last edge and CS deassert (must be >= 1)

Ports:
clk_in  input  1  system clock
reset_n_in  input  1  reset; asynchronous, active-low
data_in  input  MAX_SIZE  transmit word, right-aligned
frame_len_in  input  $clog2(MAX_SIZE+1)  frame length in bits
cpol_in  input  1  SCLK idle level
cpha_in  input  1  0 = sample on leading edge, 1 = sample on trailing edge
clk_count_max  input  CLK_SIZE  half-period length minus 1, in clk_in cycles
cs_select_in  input  $clog2(CS_SIZE)  chip-select index
start_in  input  1  request a frame
serial_in  input  1  MISO
data_out  output  MAX_SIZE  received word, right-aligned, upper bits zero
clk_out  output  1  SCLK
serial_out  output  1  MOSI
cs_out_n  output  CS_SIZE  chip selects, active-low
r_ready_out  output  1  high when idle and able to accept start_in
r_done_out  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset values: r_ready_out=1, r_done_out=0, cs_out_n=all 1, clk_out=0, serial_out=0, data_out=0, FSM=IDLE.
- Reset mid-frame aborts the frame immediately. No done pulse is produced, and data_out is not updated.
- Half-period tick: an internal counter runs 0..clk_count_max and emits a tick on wrap. The counter is held at 0 in IDLE. One half-period = clk_count_max+1 cycles; clk_count_max=0 gives SCLK = clk_in/2.
- Start accepted: start_in=1 while r_ready_out=1. On acceptance the block:
  - latches data_in, frame_len_in, cpol_in, cpha_in, cs_select_in and clk_count_max;
  - drops r_ready_out the next cycle.
- Input changes during a frame have no effect.
- start_in while busy is ignored and is not queued.
- Length rules:
  - frame_len_in > MAX_SIZE is clamped to MAX_SIZE.
  - frame_len_in = 0: no CS assert and no SCLK activity; r_done_out pulses the cycle after acceptance; data_out is unchanged; r_ready_out returns high the cycle after that.
- FSM states IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE.
- IDLE:
  - clk_out = cpol_in, driven combinationally from the live input.
  - All CS lines high.
- SETUP:
  - cs_out_n[sel]=0; all other CS lines stay high.
  - serial_out = bit len-1 when cpha=0; otherwise it holds its previous value.
  - Lasts CS_GAP ticks.
- TRANSFER:
  - Lasts exactly 2*len ticks. clk_out toggles on every tick, starting from level cpol.
  - Edge k = 1..2*len; odd k is the leading edge.
  - cpha=0: sample serial_in on leading edges; shift the next MOSI bit on trailing edges, except after the final edge.
  - cpha=1: shift the MOSI bit on leading edges (bit len-1 first); sample on trailing edges.
  - Bit order is MSB-first from bit len-1. The receive shift register shifts left, LSB-in.
- HOLD:
  - clk_out = cpol; CS stays asserted for CS_GAP ticks.
  - On the final tick: CS deasserts, data_out updates with the received bits (bits >= len are zero), and r_done_out pulses for one cycle.
  - The next cycle returns to IDLE with r_ready_out=1.
- Busy time (r_ready_out low) = (2*CS_GAP + 2*len)*(clk_count_max+1) cycles, +/-1 for the registered ready.
- data_out holds its value until the next completed frame.
- Only one CS line is ever low at a time. cs_select_in >= CS_SIZE selects no line; the frame still runs.

Test Plan:
- Mode 0, len=8, data_in=0xA5, serial_out looped to serial_in, clk_count_max=1, sel=2 -> cs_out_n=4'b1011 during the frame; 16 SCLK edges, idle low; data_out=0xA5; done pulse once; busy time ~36 cycles.
- Mode 3 (cpol=1, cpha=1), len=16, data_in=0x1234, external MISO model returning 0xBEEF -> clk_out idles high; MOSI changes on falling edges; data_out=0xBEEF; the device model sees 0x1234.
- len=40, data_in=0xF0_0F_AA_55_C3, loopback, mode 1 -> data_out is identical; exactly 80 edges.
- len=0 and len=50 (clamped to 40) -> len=0: no CS/SCLK activity, done after 1 cycle, data_out unchanged. len=50: 80 edges.
- start_in pulsed mid-frame and data_in changed mid-frame -> no second frame; the transmitted word equals the latched value.
- reset_n_in low at edge 5 of an 8-bit frame -> same clk_in cycle: cs_out_n all 1, clk_out=0, r_ready_out=1. No done pulse; data_out is unchanged.

Source files
------------

// File: rtl/spi_master_multi.sv
// SPI master with run-time CPOL/CPHA, variable frame length and a start/ready/done handshake.
// One shared bus drives CS_SIZE active-low chip selects; everything runs on clk_in.
module spi_master_multi #(
  parameter int unsigned MAX_SIZE = 40,
  parameter int unsigned CS_SIZE  = 4,
  parameter int unsigned CLK_SIZE = 8,
  parameter int unsigned CS_GAP   = 1
) (
  input  logic                          clk_in,
  input  logic                          reset_n_in,
  input  logic [MAX_SIZE-1:0]           data_in,
  input  logic [$clog2(MAX_SIZE+1)-1:0] frame_len_in,
  input  logic                          cpol_in,
  input  logic                          cpha_in,
  input  logic [CLK_SIZE-1:0]           clk_count_max,
  input  logic [$clog2(CS_SIZE)-1:0]    cs_select_in,
  input  logic                          start_in,
  input  logic                          serial_in,
  output logic [MAX_SIZE-1:0]           data_out,
  output logic                          clk_out,
  output logic                          serial_out,
  output logic [CS_SIZE-1:0]            cs_out_n,
  output logic                          r_ready_out,
  output logic                          r_done_out
);

  localparam int unsigned LW = $clog2(MAX_SIZE + 1);
  localparam int unsigned EW = LW + 1;
  localparam int unsigned SW = $clog2(CS_SIZE);
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CLK_SIZE-1:0]   cnt_q, cnt_d;
  logic [CLK_SIZE-1:0]   cmax_q, cmax_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic [MAX_SIZE-1:0]   tx_q, tx_d;
  logic [MAX_SIZE-1:0]   rx_q, rx_d;
  logic [MAX_SIZE-1:0]   dout_q, dout_d;
  logic [CS_SIZE-1:0]    cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  logic [LW-1:0]         len_c;
  logic [MAX_SIZE-1:0]   shifted_c;
  logic [CS_SIZE-1:0]    cs_dec_c;
  logic                  tick_c, accept_c, lead_c, last_c, gap_last_c;

  // Clamped length, MSB-aligned transmit word, chip-select decode and event strobes
  always_comb begin
    len_c      = (frame_len_in > LW'(MAX_SIZE)) ? LW'(MAX_SIZE) : frame_len_in;
    shifted_c  = data_in << (MAX_SIZE - 32'(len_c));
    cs_dec_c   = '1;
    for (int i = 0; i < CS_SIZE; i++) begin
      if (cs_select_in == SW'(i)) cs_dec_c[i] = 1'b0;
    end
    tick_c     = (state_q != IDLE) && (cnt_q == cmax_q);
    accept_c   = (state_q == IDLE) && ready_q && start_in;
    lead_c     = ~edge_q[0];
    last_c     = (edge_q + EW'(1)) == {len_q, 1'b0};
    gap_last_c = (gap_q == GW'(CS_GAP - 1));
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick_c) ? '0 : cnt_q + CLK_SIZE'(1);
    cmax_d  = cmax_q;
    gap_d   = gap_q;
    edge_d  = edge_q;
    len_d   = len_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ready_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        cs_n_d  = '1;
        if (accept_c) begin
          ready_d = 1'b0;
          len_d   = len_c;
          cpol_d  = cpol_in;
          cpha_d  = cpha_in;
          cmax_d  = clk_count_max;
          sclk_d  = cpol_in;
          rx_d    = '0;
          edge_d  = '0;
          gap_d   = '0;
          if (len_c == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SETUP;
            cs_n_d  = cs_dec_c;
            // cpha=0 presents the first bit before the leading edge
            if (!cpha_in) begin
              mosi_d = shifted_c[MAX_SIZE-1];
              tx_d   = shifted_c << 1;
            end else begin
              tx_d   = shifted_c;
            end
          end
        end
      end

      SETUP: begin
        if (tick_c) begin
          if (gap_last_c) begin
            gap_d   = '0;
            state_d = TRANSFER;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end

      TRANSFER: begin
        if (tick_c) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EW'(1);
          if (lead_c ^ cpha_q) rx_d = {rx_q[MAX_SIZE-2:0], serial_in};
          if (cpha_q ? lead_c : (!lead_c && !last_c)) begin
            mosi_d = tx_q[MAX_SIZE-1];
            tx_d   = tx_q << 1;
          end
          if (last_c) state_d = HOLD;
        end
      end

      HOLD: begin
        sclk_d = cpol_q;
        if (tick_c) begin
          if (gap_last_c) begin
            gap_d   = '0;
            state_d = IDLE;
            cs_n_d  = '1;
            dout_d  = rx_q;
            done_d  = 1'b1;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmax_q  <= '0;
      gap_q   <= '0;
      edge_q  <= '0;
      len_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cs_n_q  <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmax_q  <= cmax_d;
      gap_q   <= gap_d;
      edge_q  <= edge_d;
      len_q   <= len_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // SCLK follows the live CPOL input while idle so the idle level tracks mode changes
  assign clk_out     = (state_q == IDLE) ? (cpol_in & reset_n_in) : sclk_q;
  assign serial_out  = mosi_q;
  assign cs_out_n    = cs_n_q;
  assign data_out    = dout_q;
  assign r_ready_out = ready_q;
  assign r_done_out  = done_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed self-checking bench for spi_master_multi: loopback and slave-model frames,
// length boundaries, busy-time start/data changes and mid-frame reset.
module tb_spi_master_multi;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic [39:0] data_in;
  logic [5:0]  frame_len_in;
  logic        cpol_in;
  logic        cpha_in;
  logic [7:0]  clk_count_max;
  logic [1:0]  cs_select_in;
  logic        start_in;
  logic        serial_in;
  logic [39:0] data_out;
  logic        clk_out;
  logic        serial_out;
  logic [3:0]  cs_out_n;
  logic        r_ready_out;
  logic        r_done_out;

  logic        loopback;
  logic        miso;
  logic        model_en;
  logic [15:0] slave_tx;
  logic [15:0] slave_rx;

  int          errors = 0;
  int          checks = 0;
  int          edges = 0;
  int          done_cnt = 0;
  int          busy = 0;
  logic [3:0]  cs_seen = 4'h0;
  logic        multi_low = 1'b0;
  logic        first_lvl = 1'b0;
  bit          to;

  spi_master_multi dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .data_in       (data_in),
    .frame_len_in  (frame_len_in),
    .cpol_in       (cpol_in),
    .cpha_in       (cpha_in),
    .clk_count_max (clk_count_max),
    .cs_select_in  (cs_select_in),
    .start_in      (start_in),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .clk_out       (clk_out),
    .serial_out    (serial_out),
    .cs_out_n      (cs_out_n),
    .r_ready_out   (r_ready_out),
    .r_done_out    (r_done_out)
  );

  always #5 clk_in = ~clk_in;

  assign serial_in = loopback ? serial_out : miso;

  always @(clk_out) begin
    if (edges == 0) first_lvl = clk_out;
    edges = edges + 1;
  end

  always @(posedge clk_in) begin
    if (r_done_out) done_cnt = done_cnt + 1;
    if (!r_ready_out) busy = busy + 1;
    cs_seen = cs_seen | ~cs_out_n;
    if ($countones(~cs_out_n) > 1) multi_low = 1'b1;
  end

  // Mode-3 slave on CS0: drive MISO on falling (leading) edges, capture MOSI on rising
  always @(negedge clk_out) begin
    if (model_en && !cs_out_n[0]) begin
      miso     = slave_tx[15];
      slave_tx = slave_tx << 1;
    end
  end

  always @(posedge clk_out) begin
    if (model_en && !cs_out_n[0]) slave_rx = {slave_rx[14:0], serial_out};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [39:0] d, input int len, input logic pol,
                             input logic pha, input int cmax, input int sel);
    @(posedge clk_in); #1;
    data_in       = d;
    frame_len_in  = 6'(len);
    cpol_in       = pol;
    cpha_in       = pha;
    clk_count_max = 8'(cmax);
    cs_select_in  = 2'(sel);
    @(posedge clk_in); #1;
    edges    = 0;
    cs_seen  = 4'h0;
    done_cnt = 0;
    busy     = 0;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_in); #1;
      if (r_done_out) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  initial begin
    reset_n_in    = 1'b0;
    data_in       = '0;
    frame_len_in  = '0;
    cpol_in       = 1'b0;
    cpha_in       = 1'b0;
    clk_count_max = '0;
    cs_select_in  = '0;
    start_in      = 1'b0;
    loopback      = 1'b1;
    miso          = 1'b0;
    model_en      = 1'b0;
    slave_tx      = '0;
    slave_rx      = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_ready", 64'(r_ready_out), 64'd1);
    chk("rst_done",  64'(r_done_out),  64'd0);
    chk("rst_cs",    64'(cs_out_n),    64'hF);
    chk("rst_sclk",  64'(clk_out),     64'd0);
    chk("rst_mosi",  64'(serial_out),  64'd0);
    reset_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("rst_dout",  64'(data_out),    64'd0);

    // Reset asserted right after edge 5 of an 8-bit frame
    start_frame(40'h99, 8, 1'b0, 1'b0, 1, 0);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_in); #1;
      if (edges >= 5) begin
        to = 1'b0;
        break;
      end
    end
    chk("mrst_reach_edge5", 64'(to), 64'd0);
    chk("mrst_sclk_before", 64'(clk_out), 64'd1);
    reset_n_in = 1'b0;
    #1;
    chk("mrst_cs",    64'(cs_out_n),    64'hF);
    chk("mrst_sclk",  64'(clk_out),     64'd0);
    chk("mrst_ready", 64'(r_ready_out), 64'd1);
    repeat (2) @(posedge clk_in);
    #1;
    reset_n_in = 1'b1;
    repeat (40) @(posedge clk_in);
    #1;
    chk("mrst_no_done", 64'(done_cnt), 64'd0);
    chk("mrst_dout",    64'(data_out), 64'd0);

    // Mode 0, 8 bits, loopback, CS2
    multi_low = 1'b0;
    start_frame(40'hA5, 8, 1'b0, 1'b0, 1, 2);
    wait_done(200, to);
    chk("m0_timeout", 64'(to),        64'd0);
    chk("m0_dout",    64'(data_out),  64'hA5);
    chk("m0_edges",   64'(edges),     64'd16);
    chk("m0_cs",      64'(cs_seen),   64'b0100);
    chk("m0_done",    64'(done_cnt),  64'd1);
    chk("m0_busy",    64'(busy >= 35 && busy <= 38), 64'd1);
    chk("m0_idle",    64'(clk_out),   64'd0);
    chk("m0_ready",   64'(r_ready_out), 64'd1);

    // Mode 3, 16 bits against a slave returning 0xBEEF
    loopback = 1'b0;
    model_en = 1'b1;
    slave_tx = 16'hBEEF;
    slave_rx = 16'h0;
    start_frame(40'h1234, 16, 1'b1, 1'b1, 0, 0);
    wait_done(200, to);
    chk("m3_timeout",  64'(to),        64'd0);
    chk("m3_dout",     64'(data_out),  64'hBEEF);
    chk("m3_slave_rx", 64'(slave_rx),  64'h1234);
    chk("m3_edges",    64'(edges),     64'd32);
    chk("m3_first_fall", 64'(first_lvl), 64'd0);
    chk("m3_idle",     64'(clk_out),   64'd1);
    model_en = 1'b0;
    loopback = 1'b1;

    // Mode 1, full 40-bit frame, loopback, CS1
    start_frame(40'hF0_0F_AA_55_C3, 40, 1'b0, 1'b1, 2, 1);
    wait_done(1000, to);
    chk("m1_timeout", 64'(to),       64'd0);
    chk("m1_dout",    64'(data_out), 64'hF0_0F_AA_55_C3);
    chk("m1_edges",   64'(edges),    64'd80);
    chk("m1_cs",      64'(cs_seen),  64'b0010);

    // Zero-length frame: immediate done, no bus activity
    start_frame(40'h77, 0, 1'b0, 1'b0, 1, 3);
    chk("z_done",     64'(r_done_out),  64'd1);
    chk("z_ready_lo", 64'(r_ready_out), 64'd0);
    @(posedge clk_in); #1;
    chk("z_done_off", 64'(r_done_out),  64'd0);
    chk("z_ready_hi", 64'(r_ready_out), 64'd1);
    repeat (10) @(posedge clk_in);
    #1;
    chk("z_cs",    64'(cs_seen),  64'h0);
    chk("z_edges", 64'(edges),    64'd0);
    chk("z_dout",  64'(data_out), 64'hF0_0F_AA_55_C3);
    chk("z_count", 64'(done_cnt), 64'd1);

    // Length 50 clamps to the full 40 bits
    start_frame(40'h12_3456_789A, 50, 1'b0, 1'b0, 0, 0);
    wait_done(500, to);
    chk("c_timeout", 64'(to),       64'd0);
    chk("c_dout",    64'(data_out), 64'h12_3456_789A);
    chk("c_edges",   64'(edges),    64'd80);

    // Start pulse and data change during a frame are ignored
    start_frame(40'h3C, 8, 1'b0, 1'b0, 1, 3);
    repeat (6) @(posedge clk_in);
    #1;
    data_in  = 40'hFF_FFFF_FFFF;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    wait_done(200, to);
    chk("b_timeout", 64'(to),       64'd0);
    chk("b_dout",    64'(data_out), 64'h3C);
    chk("b_cs",      64'(cs_seen),  64'b1000);
    cs_seen = 4'h0;
    repeat (60) @(posedge clk_in);
    #1;
    chk("b_no_second_cs",   64'(cs_seen),  64'h0);
    chk("b_no_second_done", 64'(done_cnt), 64'd1);
    chk("one_cs_low",       64'(multi_low), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
